// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the sequencing controller: state encoding, instruction
// field codes, writeback/register select codes and the per-state control decode.
package cpu_defs_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_IF_REQ,
        S_IF_LOAD,
        S_PC_INC,
        S_DECODE,
        S_MOV_IMM,
        S_RD_A,
        S_RD_B,
        S_ALU,
        S_WB,
        S_MEM_ADDR,
        S_ADDR_LD,
        S_MEM_REQ,
        S_LD_WB,
        S_ST_RD,
        S_ST_C,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_PC     = 2'b10;
    localparam logic [1:0] VSEL_C      = 2'b11;

    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [2:0] NSEL_NONE = 3'b000;

    // Instruction class latched at DECODE; K_MOVR covers both MOV-reg and MVN
    // because they share the single-operand B-only path with asel=1.
    typedef enum logic [2:0] {
        K_MOVI,
        K_MOVR,
        K_ALU,
        K_CMP,
        K_LDR,
        K_STR,
        K_HALT,
        K_ILL
    } cls_t;

    typedef struct packed {
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [2:0] nsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic       mem_req;
        logic       mem_we;
        logic       w;
        logic       halted;
    } ctrl_t;

    function automatic cls_t classify(input logic [2:0] opcode, input logic [1:0] op);
        cls_t k;
        k = K_ILL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      k = K_MOVI;
                else if (op == OP_MOV_REG) k = K_MOVR;
                else                       k = K_ILL;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD, OP_AND: k = K_ALU;
                    OP_CMP:         k = K_CMP;
                    OP_MVN:         k = K_MOVR;
                    default:        k = K_ILL;
                endcase
            end
            OPC_LDR:  k = (op == OP_MEM) ? K_LDR : K_ILL;
            OPC_STR:  k = (op == OP_MEM) ? K_STR : K_ILL;
            OPC_HALT: k = K_HALT;
            default:  k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic ctrl_t ctrl_of(input state_t st, input cls_t k);
        ctrl_t c;
        c = '0;
        c.nsel = NSEL_NONE;
        c.vsel = VSEL_MDATA;
        case (st)
            S_IDLE: begin
                c.w        = 1'b1;
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF_REQ: begin
                c.addr_sel = 1'b1;
                c.mem_req  = 1'b1;
            end
            S_IF_LOAD: c.load_ir = 1'b1;
            S_PC_INC:  c.load_pc = 1'b1;
            S_MOV_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_SXIMM8;
                c.write = 1'b1;
            end
            S_RD_A: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_RD_B: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALU: begin
                c.asel = (k == K_MOVR);
                if (k == K_CMP) c.loads = 1'b1;
                else            c.loadc = 1'b1;
            end
            S_WB: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_MEM_ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_ADDR_LD: c.load_addr = 1'b1;
            S_ST_RD: begin
                c.nsel  = NSEL_RD;
                c.loadb = 1'b1;
            end
            // Pass B through the ALU (A forced to zero) so C carries the store data.
            S_ST_C: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_MEM_REQ: begin
                c.mem_req = 1'b1;
                c.mem_we  = (k == K_STR);
            end
            S_LD_WB: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_MDATA;
                c.write = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request and flags when the
// configured limit has been reached.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int WCNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_MAX);

    logic [WCNT_W-1:0] count;

    // Saturates at LIMIT so a stalled request cannot wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + WCNT_W'(1);
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle sequencing controller: fetch, decode and execute of MOV/ALU/LDR/STR
// with bounded memory waits; all strobes are registered decodes of the next state.
module seq_controller
    import cpu_defs_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WCNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_rdy,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic [2:0] nsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic       mem_req,
    output logic       mem_we,
    output logic       w,
    output logic       halted,
    output logic       err,
    output logic [4:0] state_dbg
);

    state_t state, next_state;
    cls_t   cls, dec_cls, next_cls;
    ctrl_t  ctrl_q;
    logic   err_set;
    logic   in_req;
    logic   timeout;

    // Handshake: mem_req stays high for the whole request state; mem_rdy is an
    // acknowledge sampled only while in IF_REQ/MEM_REQ and ignored elsewhere.
    assign in_req = (state == S_IF_REQ) || (state == S_MEM_REQ);

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX),
        .WCNT_W  (WCNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_req || mem_rdy),
        .enable (in_req),
        .timeout(timeout)
    );

    assign dec_cls  = classify(opcode, op);
    assign next_cls = (state == S_DECODE) ? dec_cls : cls;

    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        case (state)
            S_IDLE:    if (s) next_state = S_IF_REQ;
            S_IF_REQ: begin
                if (mem_rdy) begin
                    next_state = S_IF_LOAD;
                end else if (timeout) begin
                    next_state = S_HALT;
                    err_set    = 1'b1;
                end
            end
            S_IF_LOAD: next_state = S_PC_INC;
            S_PC_INC:  next_state = S_DECODE;
            S_DECODE: begin
                case (dec_cls)
                    K_MOVI:                      next_state = S_MOV_IMM;
                    K_MOVR:                      next_state = S_RD_B;
                    K_ALU, K_CMP, K_LDR, K_STR:  next_state = S_RD_A;
                    K_HALT:                      next_state = S_HALT;
                    default: begin
                        next_state = S_HALT;
                        err_set    = 1'b1;
                    end
                endcase
            end
            S_MOV_IMM:  next_state = S_IF_REQ;
            S_RD_A:     next_state = (cls == K_LDR || cls == K_STR) ? S_MEM_ADDR : S_RD_B;
            S_RD_B:     next_state = S_ALU;
            S_ALU:      next_state = (cls == K_CMP) ? S_IF_REQ : S_WB;
            S_WB:       next_state = S_IF_REQ;
            // Stores fetch Rd into B while C still holds the address, latch the
            // address, and only then overwrite C with the store data.
            S_MEM_ADDR: next_state = (cls == K_STR) ? S_ST_RD : S_ADDR_LD;
            S_ST_RD:    next_state = S_ADDR_LD;
            S_ADDR_LD:  next_state = (cls == K_STR) ? S_ST_C : S_MEM_REQ;
            S_ST_C:     next_state = S_MEM_REQ;
            S_MEM_REQ: begin
                if (mem_rdy) begin
                    next_state = (cls == K_LDR) ? S_LD_WB : S_IF_REQ;
                end else if (timeout) begin
                    next_state = S_HALT;
                    err_set    = 1'b1;
                end
            end
            S_LD_WB:    next_state = S_IF_REQ;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cls      <= K_HALT;
            ctrl_q   <= '0;
            ctrl_q.w <= 1'b1;
            err      <= 1'b0;
        end else begin
            state  <= next_state;
            cls    <= next_cls;
            ctrl_q <= ctrl_of(next_state, next_cls);
            err    <= err | err_set;
        end
    end

    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign vsel      = ctrl_q.vsel;
    assign nsel      = ctrl_q.nsel;
    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign mem_req   = ctrl_q.mem_req;
    assign mem_we    = ctrl_q.mem_we;
    assign w         = ctrl_q.w;
    assign halted    = ctrl_q.halted;
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: per-instruction observation of strobes and latency
// compared with a cycle-count model of the instruction sequences.
module tb_seq_controller;

  localparam int WM = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic       mem_rdy = 1'b0;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic [2:0] nsel;
  logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_req, mem_we;
  logic       w, halted, err;
  logic [4:0] state_dbg;
  logic [18:0] strobes;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] lat;
    logic [7:0] freq;
    logic [7:0] dreq;
    logic [7:0] dwe;
    logic [7:0] dk;
    logic [7:0] fa;
    logic [7:0] fb;
    logic [7:0] fc;
    logic [7:0] fw;
    logic [7:0] fs;
    logic [3:0] nwr;
    logic [3:0] nla;
    logic [3:0] nlb;
    logic [3:0] nlc;
    logic [3:0] nls;
    logic [3:0] nas;
    logic [3:0] nbs;
    logic [3:0] nad;
    logic [2:0] wnsel;
    logic [1:0] wvsel;
    logic       hlt;
    logic       er;
    logic       clean;
  } obs_t;

  seq_controller #(.WAIT_MAX(WM), .WCNT_W(4)) dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op), .mem_rdy(mem_rdy),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .nsel(nsel), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel), .load_addr(load_addr),
    .mem_req(mem_req), .mem_we(mem_we), .w(w), .halted(halted), .err(err),
    .state_dbg(state_dbg)
  );

  assign strobes = {write, loada, loadb, loadc, loads, asel, bsel, vsel, nsel, load_ir,
                    load_pc, reset_pc, addr_sel, load_addr, mem_req, mem_we};

  always #5 clk = ~clk;

  // Expected behaviour of one instruction, offsets counted from the DECODE cycle.
  function automatic obs_t exp_of(input logic [2:0] opc, input logic [1:0] o,
                                  input int fd, input int md);
    obs_t e;
    int   ms;
    logic str;
    e = '0;
    if (fd > WM) begin
      e.freq = 8'(WM + 1);
      e.hlt = 1'b1; e.er = 1'b1; e.clean = 1'b1;
      return e;
    end
    e.freq = 8'(fd + 1);
    e.dk = 8'(fd + 3);
    if (opc == 3'b111) begin
      e.lat = 8'd1; e.hlt = 1'b1; e.clean = 1'b1;
    end else if (opc == 3'b110 && o == 2'b10) begin
      e.nwr = 4'd1; e.fw = 8'd1; e.wnsel = 3'b100; e.wvsel = 2'b01; e.lat = 8'd2;
    end else if (opc == 3'b101 && (o == 2'b00 || o == 2'b10)) begin
      e.nla = 4'd1; e.fa = 8'd1; e.nlb = 4'd1; e.fb = 8'd2; e.nlc = 4'd1; e.fc = 8'd3;
      e.nwr = 4'd1; e.fw = 8'd4; e.wnsel = 3'b010; e.wvsel = 2'b11; e.lat = 8'd5;
    end else if (opc == 3'b101 && o == 2'b01) begin
      e.nla = 4'd1; e.fa = 8'd1; e.nlb = 4'd1; e.fb = 8'd2; e.nls = 4'd1; e.fs = 8'd3;
      e.lat = 8'd4;
    end else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
      e.nlb = 4'd1; e.fb = 8'd1; e.nlc = 4'd1; e.fc = 8'd2; e.nas = 4'd1;
      e.nwr = 4'd1; e.fw = 8'd3; e.wnsel = 3'b010; e.wvsel = 2'b11; e.lat = 8'd4;
    end else if ((opc == 3'b011 || opc == 3'b100) && o == 2'b00) begin
      str = (opc == 3'b100);
      e.nla = 4'd1; e.fa = 8'd1; e.fc = 8'd2; e.nbs = 4'd1; e.nad = 4'd1;
      ms = str ? 6 : 4;
      if (str) begin
        e.nlc = 4'd2; e.nlb = 4'd1; e.fb = 8'd3; e.nas = 4'd1;
      end else begin
        e.nlc = 4'd1;
      end
      if (md > WM) begin
        e.dreq = 8'(WM + 1);
        e.dwe = str ? 8'(WM + 1) : 8'd0;
        e.lat = 8'(ms + WM + 1);
        e.hlt = 1'b1; e.er = 1'b1; e.clean = 1'b1;
      end else begin
        e.dreq = 8'(md + 1);
        e.dwe = str ? 8'(md + 1) : 8'd0;
        if (!str) begin
          e.nwr = 4'd1; e.fw = 8'(ms + md + 1); e.wnsel = 3'b010; e.wvsel = 2'b00;
        end
        e.lat = str ? 8'(ms + md + 1) : 8'(ms + md + 2);
      end
    end else begin
      e.lat = 8'd1; e.hlt = 1'b1; e.er = 1'b1; e.clean = 1'b1;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_prog();
    int g = 0;
    s = 1'b1;
    while (!(mem_req && addr_sel) && g < 10) begin
      @(negedge clk); g++;
    end
    n_vec++;
    if (!(mem_req && addr_sel)) begin
      n_bad++;
      $display("FAIL start_fetch: mem_req=%b addr_sel=%b, required 1 1 within 10 cycles", mem_req, addr_sel);
    end
  endtask

  // Runs from the current fetch cycle up to the next fetch cycle (or HALT),
  // acting as memory with the given fetch/data acknowledge delays.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                           input int fd, input int md, output obs_t r);
    int k = 0, dk = 0, run = 0, off;
    logic done = 1'b0, dseen = 1'b0, prev_lpc = 1'b0;
    logic [1:0] pkey = 2'b00;
    r = '0;
    opcode = opc; op = o;
    while (!done && k < 200) begin
      if (prev_lpc && !dseen) begin dseen = 1'b1; dk = k; end
      if (halted) begin
        r.hlt = 1'b1; r.er = err;
        r.clean = (strobes == 19'd0) && !w;
        r.lat = dseen ? 8'(k - dk) : 8'd0;
        done = 1'b1;
      end else if (dseen && mem_req && addr_sel) begin
        r.lat = 8'(k - dk);
        done = 1'b1;
      end else begin
        off = dseen ? k - dk : 0;
        if (mem_req && addr_sel) r.freq = r.freq + 8'd1;
        if (mem_req && !addr_sel) r.dreq = r.dreq + 8'd1;
        if (mem_we) r.dwe = r.dwe + 8'd1;
        if (write) begin
          r.nwr = r.nwr + 4'd1;
          if (r.nwr == 4'd1) r.fw = 8'(off);
          r.wnsel = nsel; r.wvsel = vsel;
        end
        if (loada) begin r.nla = r.nla + 4'd1; if (r.nla == 4'd1) r.fa = 8'(off); end
        if (loadb) begin r.nlb = r.nlb + 4'd1; if (r.nlb == 4'd1) r.fb = 8'(off); end
        if (loadc) begin r.nlc = r.nlc + 4'd1; if (r.nlc == 4'd1) r.fc = 8'(off); end
        if (loads) begin r.nls = r.nls + 4'd1; if (r.nls == 4'd1) r.fs = 8'(off); end
        if (asel) r.nas = r.nas + 4'd1;
        if (bsel) r.nbs = r.nbs + 4'd1;
        if (load_addr) r.nad = r.nad + 4'd1;
        if ({mem_req, addr_sel} != pkey) run = 0; else run++;
        pkey = {mem_req, addr_sel};
        if (mem_req) mem_rdy = (run >= (addr_sel ? fd : md));
        else mem_rdy = 1'($urandom_range(0, 1));
        prev_lpc = load_pc && !w;
        @(negedge clk);
        k++;
      end
    end
    r.dk = dseen ? 8'(dk) : 8'd0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL run_timeout: opcode=%b op=%b did not reach next fetch or HALT in 200 cycles", opc, o);
    end
  endtask

  task automatic test_reset();
    int idle_n = 0;
    do_reset();
    n_vec++;
    if ({strobes, w, halted, err} !== {19'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: strobes=%h w=%b halted=%b err=%b, required 0 1 0 0", strobes, w, halted, err);
    end
    @(negedge clk);
    n_vec++;
    if ({w, load_pc, reset_pc, mem_req, write, halted} !== 6'b111000) begin
      n_bad++;
      $display("FAIL idle_strobes: w/load_pc/reset_pc/mem_req/write/halted=%b, required 111000",
               {w, load_pc, reset_pc, mem_req, write, halted});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (w && !mem_req) idle_n++;
    end
    n_vec++;
    if (idle_n != 3) begin
      n_bad++;
      $display("FAIL idle_hold: idle cycles=%0d, required 3", idle_n);
    end
  endtask

  task automatic test_mov_imm();
    obs_t r, e;
    do_reset(); start_prog();
    run_instr(3'b110, 2'b10, 0, 0, r);
    e = exp_of(3'b110, 2'b10, 0, 0);
    n_vec++;
    if (r !== e) begin n_bad++; $display("FAIL mov_imm: got %h required %h", r, e); end
  endtask

  task automatic test_alu();
    obs_t r, e;
    logic [4:0] ins [4] = '{5'b101_00, 5'b101_01, 5'b110_00, 5'b101_11};
    for (int i = 0; i < 4; i++) begin
      run_instr(ins[i][4:2], ins[i][1:0], 0, 0, r);
      e = exp_of(ins[i][4:2], ins[i][1:0], 0, 0);
      n_vec++;
      if (r !== e) begin n_bad++; $display("FAIL alu_%b: got %h required %h", ins[i], r, e); end
    end
  endtask

  task automatic test_str_delay3();
    obs_t r, e;
    run_instr(3'b100, 2'b00, 1, 3, r);
    e = exp_of(3'b100, 2'b00, 1, 3);
    n_vec++;
    if (r !== e) begin n_bad++; $display("FAIL str_delay3: got %h required %h", r, e); end
    run_instr(3'b011, 2'b00, 2, WM, r);
    e = exp_of(3'b011, 2'b00, 2, WM);
    n_vec++;
    if (r !== e) begin n_bad++; $display("FAIL ldr_ack_at_limit: got %h required %h", r, e); end
  endtask

  task automatic test_ldr_timeout();
    obs_t r, e;
    int held = 0;
    run_instr(3'b011, 2'b00, 0, 1000, r);
    e = exp_of(3'b011, 2'b00, 0, 1000);
    n_vec++;
    if (r !== e) begin n_bad++; $display("FAIL ldr_timeout: got %h required %h", r, e); end
    for (int i = 0; i < 5; i++) begin
      mem_rdy = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (halted && err && strobes == 19'd0 && !w) held++;
    end
    n_vec++;
    if (held != 5) begin n_bad++; $display("FAIL halt_sticky: held cycles=%0d, required 5", held); end
    do_reset();
    n_vec++;
    if ({w, err, halted} !== 3'b100) begin
      n_bad++; $display("FAIL reset_after_halt: w/err/halted=%b, required 100", {w, err, halted});
    end
  endtask

  task automatic test_halts();
    obs_t r, e;
    logic [1:0] o;
    o = 2'($urandom_range(0, 3));
    do_reset(); start_prog();
    run_instr(3'b000, o, 1, 0, r);
    e = exp_of(3'b000, o, 1, 0);
    n_vec++;
    if (r !== e) begin n_bad++; $display("FAIL illegal_opcode: got %h required %h", r, e); end
    do_reset(); start_prog();
    run_instr(3'b111, o, 0, 0, r);
    e = exp_of(3'b111, o, 0, 0);
    n_vec++;
    if (r !== e) begin n_bad++; $display("FAIL halt_opcode: got %h required %h", r, e); end
    do_reset(); start_prog();
    run_instr(3'b110, 2'b10, 1000, 0, r);
    e = exp_of(3'b110, 2'b10, 1000, 0);
    n_vec++;
    if (r !== e) begin n_bad++; $display("FAIL fetch_timeout: got %h required %h", r, e); end
  endtask

  task automatic test_reset_mid_req();
    int g = 0;
    do_reset(); start_prog();
    opcode = 3'b011; op = 2'b00;
    while (!(mem_req && !addr_sel) && g < 50) begin
      mem_rdy = mem_req;
      @(negedge clk); g++;
    end
    n_vec++;
    if (!(mem_req && !addr_sel)) begin
      n_bad++; $display("FAIL reach_mem_req: mem_req=%b addr_sel=%b, required 1 0", mem_req, addr_sel);
    end
    mem_rdy = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({strobes, w, halted, err} !== {19'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_req: strobes=%h w=%b halted=%b err=%b, required 0 1 0 0", strobes, w, halted, err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    obs_t r, e;
    logic [4:0] legal [8] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01,
                              5'b101_10, 5'b101_11, 5'b011_00, 5'b100_00};
    logic [4:0] pick;
    int fd, md;
    do_reset(); start_prog();
    for (int i = 0; i < 40; i++) begin
      pick = legal[$urandom_range(0, 7)];
      fd = $urandom_range(0, 4);
      md = $urandom_range(0, 6);
      run_instr(pick[4:2], pick[1:0], fd, md, r);
      e = exp_of(pick[4:2], pick[1:0], fd, md);
      n_vec++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL random_%0d ins=%b fd=%0d md=%0d: got %h required %h", i, pick, fd, md, r, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_alu();
    test_str_delay3();
    test_ldr_timeout();
    test_halts();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter WAIT_MAX, default 15, maximum memory wait cycles per request before timeout (range 1..255).
REQ-002 Parameter WCNT_W, default 4, width of the wait counter; SHALL hold WAIT_MAX.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 s  in  1  start; leaves IDLE when high.
REQ-006 opcode  in  3  instruction class from the IR decoder; op  in  2  sub-op.
REQ-007 mem_rdy  in  1  memory acknowledge for the current request.
REQ-008 write, loada, loadb, loadc, loads, asel, bsel  out  1 each  datapath strobes/selects.
REQ-009 vsel  out  2  writeback source: 00 mdata, 01 sximm8, 10 PC, 11 C.
REQ-010 nsel  out  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm, 000 none.
REQ-011 load_ir, load_pc, reset_pc, addr_sel, load_addr  out  1 each  fetch-path strobes.
REQ-012 mem_req, mem_we  out  1 each  memory request / write qualifier.
REQ-013 w  out  1  high only in IDLE; halted  out  1  high in HALT; err  out  1  sticky fault flag.

Function
REQ-014 States: IDLE, IF_REQ, IF_LOAD, PC_INC, DECODE, MOV_IMM, RD_A, RD_B, ALU, WB, MEM_ADDR, MEM_REQ, LD_WB, ST_RD, HALT.
REQ-015 All outputs SHALL be Moore (decoded from state only); any strobe not listed for a state SHALL be 0.
REQ-016 IDLE: w=1, reset_pc=1, load_pc=1 while s=0 is not held; s=1 -> IF_REQ with reset_pc=0.
REQ-017 IF_REQ: addr_sel=1, mem_req=1; mem_rdy=1 -> IF_LOAD; otherwise stay and increment wait counter.
REQ-018 IF_LOAD: load_ir=1 -> PC_INC; PC_INC: load_pc=1 -> DECODE.
REQ-019 DECODE: 110/10 -> MOV_IMM; 110/00 and 101/11 -> RD_B; 101/00,01,10 -> RD_A; 011/00 LDR and 100/00 STR -> RD_A; 111 -> HALT; anything else -> HALT with err=1.
REQ-020 MOV_IMM: nsel=100, vsel=01, write=1 -> IF_REQ.
REQ-021 RD_A: nsel=100, loada=1 -> RD_B for ALU class, -> MEM_ADDR for LDR/STR.
REQ-022 RD_B: nsel=001, loadb=1 -> ALU.
REQ-023 ALU: asel=1 for MOV-reg and MVN, else 0; bsel=0; CMP (101/01) loads=1 -> IF_REQ; others loadc=1 -> WB.
REQ-024 WB: nsel=010, vsel=11, write=1 -> IF_REQ.
REQ-025 MEM_ADDR: bsel=1 (sximm5), loadc=1 -> MEM_REQ via one extra cycle with load_addr=1; STR -> ST_RD first.
REQ-026 ST_RD: nsel=010, loadb=1, then asel=1/loadc=1 one cycle, then MEM_REQ.
REQ-027 MEM_REQ: addr_sel=0, mem_req=1, mem_we=1 for STR; mem_rdy=1 -> LD_WB (LDR) or IF_REQ (STR).
REQ-028 LD_WB: nsel=010, vsel=00, write=1 -> IF_REQ.
REQ-029 Wait counter clears on entry to IF_REQ/MEM_REQ; reaching WAIT_MAX without mem_rdy -> HALT, err=1.
REQ-030 mem_rdy outside IF_REQ/MEM_REQ SHALL be ignored; mem_rdy on the cycle the counter hits WAIT_MAX counts as acknowledge.
REQ-031 HALT: halted=1, all strobes 0; remains until reset.
REQ-032 Minimum latency from DECODE: MOV imm 2, ADD 5, CMP 4, LDR 6 + wait, STR 7 + wait cycles to next IF_REQ.

Reset
REQ-033 reset=1 SHALL force IDLE, w=1, err=0, wait counter 0, all other outputs 0 at next edge, from any state including mid-request.

Structure
REQ-034 State encodings, opcode/op constants, vsel and nsel codes SHALL live in shared package cpu_defs_pkg.
REQ-035 Wait counter SHALL be sub-module mem_wait_timer (clear, enable, timeout out).

Verification
REQ-036 reset, s=1, mem_rdy tied 1, IR=MOV R0,#7 (110/10) -> IF_REQ,IF_LOAD,PC_INC,DECODE,MOV_IMM; write=1,nsel=100,vsel=01 exactly 1 cycle.
REQ-037 ADD (101/00) -> loada, loadb, loadc, write(nsel=010,vsel=11) on consecutive cycles, then mem_req.
REQ-038 CMP (101/01) -> loads=1 once, write never asserted.
REQ-039 STR with mem_rdy delayed 3 cycles -> mem_req=mem_we=1 for 4 cycles, then IF_REQ.
REQ-040 LDR, mem_rdy held 0, WAIT_MAX=15 -> HALT, halted=1, err=1 after 15 wait cycles; reset -> IDLE, err=0.
REQ-041 opcode 000 -> HALT with err=1; reset asserted mid-MEM_REQ -> IDLE next cycle, mem_req=0.
